// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array datapath: default matrix geometry,
// collector state encoding and a small index-width helper.
package sa_pkg;

    localparam int unsigned SA_DW      = 8;
    localparam int unsigned SA_ROWS    = 2;
    localparam int unsigned SA_COLS    = 2;
    localparam int unsigned SA_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } sa_state_e;

    // Index width for n slots, never less than one bit
    function automatic int unsigned sa_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_collect_ctrl.sv
// Collector control: IDLE/FILL/HOLD sequencing, slot index, sticky error flags.
// Optional fill watchdog enabled by macro SA_COLLECT_TIMEOUT_EN.
module sa_collect_ctrl
    import sa_pkg::*;
#(
    parameter int unsigned N       = SA_ROWS * SA_COLS,
`ifdef SA_COLLECT_TIMEOUT_EN
    parameter int unsigned TIMEOUT = SA_TIMEOUT,
`endif
    parameter int unsigned IDX_W   = sa_idx_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm_i,
    input  logic             in_en_i,
    input  logic             res_ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             wr_en_c_o,
    output logic             clr_c_o,
    output logic             res_valid_o,
    output logic             busy_o,
    output logic             err_unexp_o,
    output logic             err_ovf_o
`ifdef SA_COLLECT_TIMEOUT_EN
    ,
    output logic             err_tmo_o
`endif
);

    sa_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             res_valid_q, busy_q;
    logic             err_unexp_q, err_ovf_q;
    logic             err_unexp_d, err_ovf_d;
    logic             last_slot;
    logic             tmo_hit;
    logic             arm_acc_c, wr_en_c, set_unexp_c, set_ovf_c, clr_c;

    assign last_slot = (idx_q == IDX_W'(N - 1));

`ifdef SA_COLLECT_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_tmo_q, err_tmo_d;

    // Watchdog fires after TIMEOUT consecutive FILL cycles without strobe or arm
    assign tmo_hit = (state_q == ST_FILL) && !arm_i && !in_en_i &&
                     (tmo_cnt_q == TW'(TIMEOUT - 1));

    // Idle-cycle counter, restarted by any strobe or arm and outside FILL
    always_comb begin
        tmo_cnt_d = '0;
        if ((state_q == ST_FILL) && !arm_i && !in_en_i && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        err_tmo_d = (arm_acc_c ? 1'b0 : err_tmo_q) | tmo_hit;
    end

    // Watchdog registers
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign err_tmo_o = err_tmo_q;
`else
    assign tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; arm in FILL restarts, arm in HOLD only counts with a transfer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (arm_i) state_d = ST_FILL;
            end
            ST_FILL: begin
                if (arm_i)                       state_d = ST_FILL;
                else if (in_en_i && last_slot)   state_d = ST_HOLD;
                else if (tmo_hit)                state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (res_ready_i) state_d = arm_i ? ST_FILL : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the element file and error flags
    always_comb begin
        arm_acc_c   = 1'b0;
        wr_en_c     = 1'b0;
        set_unexp_c = 1'b0;
        set_ovf_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arm_acc_c   = arm_i;
                set_unexp_c = in_en_i && !arm_i;
            end
            ST_FILL: begin
                arm_acc_c = arm_i;
                wr_en_c   = in_en_i && !arm_i;
            end
            ST_HOLD: begin
                arm_acc_c = arm_i && res_ready_i;
                set_ovf_c = in_en_i;
            end
            default: ;
        endcase
        clr_c = arm_acc_c || tmo_hit;
    end

    // Slot index and sticky flag next values
    always_comb begin
        idx_d = idx_q;
        if (clr_c || (wr_en_c && last_slot)) begin
            idx_d = '0;
        end else if (wr_en_c) begin
            idx_d = idx_q + IDX_W'(1);
        end
        err_unexp_d = (arm_acc_c ? 1'b0 : err_unexp_q) | set_unexp_c;
        err_ovf_d   = (arm_acc_c ? 1'b0 : err_ovf_q)   | set_ovf_c;
    end

    // Index, status and error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_unexp_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            res_valid_q <= (state_d == ST_HOLD);
            busy_q      <= (state_d == ST_FILL);
            err_unexp_q <= err_unexp_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    assign idx_o       = idx_q;
    assign wr_en_c_o   = wr_en_c;
    assign clr_c_o     = clr_c;
    assign res_valid_o = res_valid_q;
    assign busy_o      = busy_q;
    assign err_unexp_o = err_unexp_q;
    assign err_ovf_o   = err_ovf_q;

endmodule

// File: rtl/sa_result_collector.sv
// Systolic-array result collector: reassembles the serialized result stream
// row-major into a ROWS x COLS matrix and offers it with valid/ready.
// Optional fill watchdog and err_tmo port enabled by macro SA_COLLECT_TIMEOUT_EN.
module sa_result_collector
    import sa_pkg::*;
#(
    parameter int unsigned DW      = SA_DW,
    parameter int unsigned ROWS    = SA_ROWS,
`ifdef SA_COLLECT_TIMEOUT_EN
    parameter int unsigned TIMEOUT = SA_TIMEOUT,
`endif
    parameter int unsigned COLS    = SA_COLS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   in_en,
    input  logic [DW-1:0]          in_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ROWS*COLS*DW-1:0] res_mat,
    output logic                   busy,
    output logic                   err_unexp,
    output logic                   err_ovf
`ifdef SA_COLLECT_TIMEOUT_EN
    ,
    output logic                   err_tmo
`endif
);

    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned IDX_W = sa_idx_w(N);

    logic [IDX_W-1:0] idx;
    logic             wr_en_c;
    logic             clr_c;
    logic [DW-1:0]    mat_q [N];

    sa_collect_ctrl #(
        .N       (N),
`ifdef SA_COLLECT_TIMEOUT_EN
        .TIMEOUT (TIMEOUT),
`endif
        .IDX_W   (IDX_W)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .arm_i       (arm),
        .in_en_i     (in_en),
        .res_ready_i (res_ready),
        .idx_o       (idx),
        .wr_en_c_o   (wr_en_c),
        .clr_c_o     (clr_c),
        .res_valid_o (res_valid),
        .busy_o      (busy),
        .err_unexp_o (err_unexp),
        .err_ovf_o   (err_ovf)
`ifdef SA_COLLECT_TIMEOUT_EN
        ,
        .err_tmo_o   (err_tmo)
`endif
    );

    // Element register file: cleared on accepted arm or abort, written per strobe
    always_ff @(posedge clk) begin
        if (reset || clr_c) begin
            for (int i = 0; i < N; i++) begin
                mat_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            mat_q[idx] <= in_data;
        end
    end

    // Flatten row-major, element (0,0) in the LSBs
    always_comb begin
        res_mat = '0;
        for (int i = 0; i < N; i++) begin
            res_mat[i*DW +: DW] = mat_q[i];
        end
    end

endmodule

// File: doc/sa_result_collector.md
Name: sa_result_collector

Overview:
- Receiving end of the systolic-array result stream. Consumes the serialized 8-bit result bytes (strobe plus data) emitted by the convolution array.
- Reassembles them, row-major, into a ROWS x COLS result matrix.
- Presents the matrix to the downstream stage with a valid/ready handshake.
- Sits between the systolic array and the output/display logic. Its arm input is tied to the same start pulse that launches the array.

Parameters:
- DW, 8, width of one result element.
- ROWS, 2, result matrix rows (4x4 image convolved with a 3x3 kernel).
- COLS, 2, result matrix columns.
- TIMEOUT, 64, cycles allowed in FILL before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse that starts a new collection; driven by the array start pulse.
- in_en  in  1  result strobe; one element is valid on in_data in each cycle it is high.
- in_data  in  DW  result element.
- res_valid  out  1  matrix is complete and held.
- res_ready  in  1  downstream accepts the matrix.
- res_mat  out  ROWS*COLS*DW  flattened matrix; element (r,c) sits at bits [(r*COLS+c)*DW +: DW]; (0,0) is in the LSBs.
- busy  out  1  high in FILL.
- err_unexp  out  1  sticky: strobe received while IDLE.
- err_ovf  out  1  sticky: strobe received while HOLD.

Behaviour:
- Reset values: state IDLE; res_mat = 0; res_valid, busy, err_unexp, err_ovf all 0; element counter idx = 0. Reset applies mid-operation too, aborting any collection.
- States: IDLE, FILL, HOLD. Encoding is 2 bits.
- IDLE:
  - arm=1 -> FILL, idx = 0, res_mat cleared to 0. Sticky error flags are cleared on arm.
  - in_en=1 without arm -> element dropped, err_unexp set.
- FILL:
  - Each cycle with in_en=1 writes in_data to slot idx and increments idx.
  - When the write lands in slot ROWS*COLS-1 -> HOLD. res_valid rises the cycle after that last strobe (latency 1 from last element).
  - arm=1 in FILL restarts: idx = 0, matrix cleared. A simultaneous in_en in that same cycle is ignored.
- HOLD:
  - res_valid=1; res_mat stable.
  - Transfer occurs on a cycle with res_valid && res_ready -> IDLE. res_valid drops the next cycle; res_mat keeps its last value until the next arm.
  - in_en=1 -> element dropped, err_ovf set, matrix unchanged.
  - arm=1 while HOLD and not transferring -> ignored (no loss of the held result).
  - arm=1 in the same cycle as the transfer -> go directly to FILL.
- Counter: idx has width clog2(ROWS*COLS). It never wraps, because the last slot forces HOLD.
- No arithmetic is performed; data is stored exactly as received (no truncation or saturation).
- busy = (state == FILL).

Optional Feature:
- Macro: SA_COLLECT_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in FILL and is reset on every in_en or arm.
  - Reaching TIMEOUT -> IDLE, and an extra output err_tmo (1 bit, sticky, cleared on arm) is set.
  - Partial data is discarded and res_valid is not asserted.
- When undefined:
  - No counter and no err_tmo port.
  - FILL waits indefinitely.

Decomposition:
- Shared package sa_pkg:
  - State enum localparams ST_IDLE=0, ST_FILL=1, ST_HOLD=2.
  - Default DW/ROWS/COLS constants, shared with the array and the operand loader.
- Sub-module sa_collect_ctrl: FSM, idx counter, error flags and the optional timeout.
- Top level holds the element register file and the output flattening.

Test Plan:
- Normal collection: reset 1 cycle; arm pulse; in_en for 4 consecutive cycles with data 10, 20, 30, 40; res_ready=1.
  - res_valid rises 1 cycle after the 4th strobe.
  - res_mat = {40,30,20,10} (MSB to LSB).
  - Returns to IDLE next cycle; no error flags set.
- Gapped strobes: arm; elements 7, 0, 255, 1 separated by 3 idle cycles each.
  - busy stays 1 throughout.
  - Final res_mat = {1,255,0,7}.
- Backpressure and overflow: complete a collection with res_ready=0 for 10 cycles, driving an extra strobe with data 99 during HOLD.
  - res_mat unchanged; err_ovf=1; res_valid held.
  - Raising res_ready -> IDLE.
  - The next arm clears err_ovf.
- Unexpected data and restart:
  - Strobe with data 5 in IDLE -> err_unexp=1.
  - Arm, 2 elements (3, 4), then arm again, then 4 elements (9, 8, 7, 6) -> res_mat = {6,7,8,9}.
- Reset mid-FILL: arm, 2 elements, then reset asserted.
  - All outputs return to 0; state IDLE.
  - A following strobe sets err_unexp.
- SA_COLLECT_TIMEOUT_EN build, TIMEOUT=64: arm, 1 element, then 64 idle cycles.
  - err_tmo=1; state IDLE; res_valid never asserted.
